text_console_ctrl: RTL and testbench



---
 rtl/text_console_pkg.sv | 34 +++
 rtl/tile_ram.sv | 30 +++
 rtl/text_console_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// Shared constants for the text console: command opcodes, special
// character codes, cursor move directions, the 16-entry colour palette
// and the controller state type.
package text_console_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUTC  = 3'd1;
    localparam logic [2:0] OP_MOVE  = 3'd2;
    localparam logic [2:0] OP_HOME  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Entry 15 is listed first so that PALETTE[i] selects colour i.
    localparam logic [15:0][11:0] PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
        12'h0AA, 12'h0A0, 12'h00F, 12'h000
    };

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port tile store: synchronous write on port A, registered
// read on port B. A read and write to the same address in one cycle
// returns the previous contents.
module tile_ram #(
    parameter int DEPTH = 7200,
    parameter int AW    = 13,
    parameter int DW    = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port A and read port B share one edge; the non-blocking read sees old data.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/text_console_ctrl.sv
// Text-mode console controller: accepts console commands into a tile
// store, tracks the cursor and its blink phase, and renders each pixel
// through a three-stage pipeline using the external glyph ROM.
module text_console_ctrl #(
    parameter int         DISP_WIDTH   = 1280,
    parameter int         DISP_HEIGHT  = 720,
    parameter int         TILE_WIDTH   = 8,
    parameter int         TILE_HEIGHT  = 16,
    parameter int         BLINK_FRAMES = 30,
    parameter logic [7:0] DEFAULT_ATTR = 8'hF1,
    localparam int COLS      = DISP_WIDTH / TILE_WIDTH,
    localparam int ROWS      = DISP_HEIGHT / TILE_HEIGHT,
    localparam int NUM_TILES = COLS * ROWS,
    localparam int TADDR_W   = $clog2(NUM_TILES),
    localparam int COL_W     = $clog2(COLS),
    localparam int ROW_W     = $clog2(ROWS),
    localparam int GA_W      = 8 + $clog2(TILE_HEIGHT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [2:0]            i_cmd_op,
    input  logic [7:0]            i_cmd_data,
    input  logic [7:0]            i_cmd_attr,
    input  logic                  i_frame_start,
    input  logic [15:0]           i_pix_x,
    input  logic [15:0]           i_pix_y,
    output logic [GA_W-1:0]       o_glyph_addr,
    input  logic [TILE_WIDTH-1:0] i_glyph_row,
    output logic [11:0]           o_pix_color,
    output logic [COL_W-1:0]      o_cursor_col,
    output logic [ROW_W-1:0]      o_cursor_row
);

    import text_console_pkg::*;

    localparam int XOFF_W  = $clog2(TILE_WIDTH);
    localparam int YOFF_W  = $clog2(TILE_HEIGHT);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [TADDR_W-1:0] LAST_TILE  = TADDR_W'(NUM_TILES - 1);
    localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_FRAMES - 1);

    ctrl_state_t         r_state, w_stateNext;
    logic [TADDR_W-1:0]  r_clrAddr, w_clrAddrNext;
    logic [7:0]          r_clearAttr, w_clearAttrNext;
    logic [COL_W-1:0]    r_cursorCol, w_colNext;
    logic [ROW_W-1:0]    r_cursorRow, w_rowNext;
    logic [ROW_W-1:0]    w_rowInc;
    logic [TADDR_W-1:0]  w_cursorAddr;
    logic [BLINK_W-1:0]  r_blinkCnt;
    logic                r_phase;

    logic                w_we;
    logic [TADDR_W-1:0]  w_wAddr;
    logic [15:0]         w_wData;

    logic                w_blank;
    logic [15:0]         w_tileCol, w_tileRow;
    logic [TADDR_W-1:0]  w_rdAddr;
    logic                w_onCursor;
    logic [15:0]         w_tileWord;
    logic [3:0]          w_fg, w_bg;

    logic [XOFF_W-1:0]   r_s1XOff, r_s2XOff;
    logic [YOFF_W-1:0]   r_s1YOff;
    logic                r_s1Cursor, r_s1Blank, r_s2Blank;
    logic [3:0]          r_s2Fg, r_s2Bg;
    logic [11:0]         r_pixColor;

    assign w_rowInc     = (r_cursorRow == LAST_ROW) ? '0 : r_cursorRow + 1'b1;
    assign w_cursorAddr = TADDR_W'(int'(r_cursorRow) * COLS + int'(r_cursorCol));

    // Controller state, clear sweep address, clear attribute and cursor registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_CLEAR;
            r_clrAddr   <= '0;
            r_clearAttr <= DEFAULT_ATTR;
            r_cursorCol <= '0;
            r_cursorRow <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_clrAddr   <= w_clrAddrNext;
            r_clearAttr <= w_clearAttrNext;
            r_cursorCol <= w_colNext;
            r_cursorRow <= w_rowNext;
        end
    end

    // Next-state, cursor movement and tile write selection for the sweep and for commands.
    always_comb begin
        w_stateNext     = r_state;
        w_clrAddrNext   = r_clrAddr;
        w_clearAttrNext = r_clearAttr;
        w_colNext       = r_cursorCol;
        w_rowNext       = r_cursorRow;
        w_we            = 1'b0;
        w_wAddr         = r_clrAddr;
        w_wData         = {CHAR_SPACE, r_clearAttr};
        o_cmd_ready     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_we = 1'b1;
                if (r_clrAddr == LAST_TILE) begin
                    w_stateNext   = ST_IDLE;
                    w_clrAddrNext = '0;
                    w_colNext     = '0;
                    w_rowNext     = '0;
                end else begin
                    w_clrAddrNext = r_clrAddr + 1'b1;
                end
            end
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    case (i_cmd_op)
                        OP_PUTC: begin
                            if (i_cmd_data == CHAR_LF) begin
                                w_colNext = '0;
                                w_rowNext = w_rowInc;
                            end else if (i_cmd_data == CHAR_CR) begin
                                w_colNext = '0;
                            end else begin
                                w_we    = 1'b1;
                                w_wAddr = w_cursorAddr;
                                w_wData = {i_cmd_data, i_cmd_attr};
                                if (r_cursorCol == LAST_COL) begin
                                    w_colNext = '0;
                                    w_rowNext = w_rowInc;
                                end else begin
                                    w_colNext = r_cursorCol + 1'b1;
                                end
                            end
                        end
                        OP_MOVE: begin
                            case (i_cmd_data[1:0])
                                DIR_UP:    if (r_cursorRow != '0)      w_rowNext = r_cursorRow - 1'b1;
                                DIR_DOWN:  if (r_cursorRow != LAST_ROW) w_rowNext = r_cursorRow + 1'b1;
                                DIR_LEFT:  if (r_cursorCol != '0)      w_colNext = r_cursorCol - 1'b1;
                                default:   if (r_cursorCol != LAST_COL) w_colNext = r_cursorCol + 1'b1;
                            endcase
                        end
                        OP_HOME: begin
                            w_colNext = '0;
                            w_rowNext = '0;
                        end
                        OP_CLEAR: begin
                            w_clearAttrNext = i_cmd_attr;
                            w_clrAddrNext   = '0;
                            w_stateNext     = ST_CLEAR;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: w_stateNext = ST_CLEAR;
        endcase
    end

    // Count frames and flip the cursor phase every BLINK_FRAMES frames.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_blinkCnt <= '0;
            r_phase    <= 1'b1;
        end else if (i_frame_start) begin
            if (r_blinkCnt == LAST_BLINK) begin
                r_blinkCnt <= '0;
                r_phase    <= ~r_phase;
            end else begin
                r_blinkCnt <= r_blinkCnt + 1'b1;
            end
        end
    end

    tile_ram #(
        .DEPTH (NUM_TILES),
        .AW    (TADDR_W),
        .DW    (16)
    ) u_tileRam (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_wAddr),
        .i_wdata (w_wData),
        .i_raddr (w_rdAddr),
        .o_rdata (w_tileWord)
    );

    // Stage 0: locate the tile under the pixel; off-screen pixels read tile 0 and are blanked later.
    assign w_blank    = (i_pix_x >= 16'(DISP_WIDTH)) || (i_pix_y >= 16'(DISP_HEIGHT));
    assign w_tileCol  = i_pix_x >> XOFF_W;
    assign w_tileRow  = i_pix_y >> YOFF_W;
    assign w_rdAddr   = w_blank ? '0 : TADDR_W'(int'(w_tileRow) * COLS + int'(w_tileCol));
    assign w_onCursor = r_phase && (w_tileCol == 16'(r_cursorCol)) && (w_tileRow == 16'(r_cursorRow));

    // Stage 1: the tile word arrives from RAM and directly addresses the glyph ROM.
    assign o_glyph_addr = {w_tileWord[15:8], r_s1YOff};
    assign w_fg         = r_s1Cursor ? w_tileWord[3:0] : w_tileWord[7:4];
    assign w_bg         = r_s1Cursor ? w_tileWord[7:4] : w_tileWord[3:0];

    // Carry pixel offsets, cursor hit and blanking alongside the RAM and ROM reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1XOff   <= '0;
            r_s1YOff   <= '0;
            r_s1Cursor <= 1'b0;
            r_s1Blank  <= 1'b1;
            r_s2XOff   <= '0;
            r_s2Fg     <= '0;
            r_s2Bg     <= '0;
            r_s2Blank  <= 1'b1;
        end else begin
            r_s1XOff   <= i_pix_x[XOFF_W-1:0];
            r_s1YOff   <= i_pix_y[YOFF_W-1:0];
            r_s1Cursor <= w_onCursor;
            r_s1Blank  <= w_blank;
            r_s2XOff   <= r_s1XOff;
            r_s2Fg     <= w_fg;
            r_s2Bg     <= w_bg;
            r_s2Blank  <= r_s1Blank;
        end
    end

    // Stage 2: pick foreground or background from the glyph bit and register the colour.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pixColor <= 12'h000;
        end else if (r_s2Blank) begin
            r_pixColor <= 12'h000;
        end else begin
            r_pixColor <= PALETTE[i_glyph_row[r_s2XOff] ? r_s2Fg : r_s2Bg];
        end
    end

    assign o_pix_color  = r_pixColor;
    assign o_cursor_col = r_cursorCol;
    assign o_cursor_row = r_cursorRow;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl with a glyph ROM model and a
// behavioural model of the tile store, cursor and blink phase.
module tb_text_console_ctrl;

    localparam int COLS = 160;
    localparam int ROWS = 45;
    localparam int NT   = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [2:0]  cmdOp = '0;
    logic [7:0]  cmdData = '0;
    logic [7:0]  cmdAttr = '0;
    logic        frameStart = 1'b0;
    logic [15:0] pixX = '0;
    logic [15:0] pixY = '0;
    logic [11:0] glyphAddr;
    logic [7:0]  glyphRow = '0;
    logic [11:0] pixColor;
    logic [7:0]  cursorCol;
    logic [5:0]  cursorRow;

    logic [15:0] mTiles [NT];
    int          mCol, mRow, mFrames;
    int          checks, failures;
    logic [11:0] streamQ [$];

    always #5 clk = ~clk;

    text_console_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmdValid),
        .o_cmd_ready   (cmdReady),
        .i_cmd_op      (cmdOp),
        .i_cmd_data    (cmdData),
        .i_cmd_attr    (cmdAttr),
        .i_frame_start (frameStart),
        .i_pix_x       (pixX),
        .i_pix_y       (pixY),
        .o_glyph_addr  (glyphAddr),
        .i_glyph_row   (glyphRow),
        .o_pix_color   (pixColor),
        .o_cursor_col  (cursorCol),
        .o_cursor_row  (cursorRow)
    );

    // Synthetic font: space is blank, every other glyph is a fixed scramble.
    function automatic logic [7:0] fontRow(input logic [7:0] ch, input logic [3:0] r);
        int v;
        if (ch == 8'h20) return 8'h00;
        v = int'(ch) * 37 + int'(r) * 29 + 11;
        return v[7:0] ^ {r, ch[3:0]};
    endfunction

    function automatic logic [11:0] tbPalette(input logic [3:0] i);
        case (i)
            4'd0:  return 12'h000;  4'd1:  return 12'h00F;
            4'd2:  return 12'h0A0;  4'd3:  return 12'h0AA;
            4'd4:  return 12'hA00;  4'd5:  return 12'hA0A;
            4'd6:  return 12'hA50;  4'd7:  return 12'hAAA;
            4'd8:  return 12'h555;  4'd9:  return 12'h55F;
            4'd10: return 12'h5F5;  4'd11: return 12'h5FF;
            4'd12: return 12'hF55;  4'd13: return 12'hF5F;
            4'd14: return 12'hFF5;  default: return 12'hFFF;
        endcase
    endfunction

    // Synchronous glyph ROM: data valid one cycle after the address.
    always @(posedge clk) glyphRow <= fontRow(glyphAddr[11:4], glyphAddr[3:0]);

    function automatic logic [11:0] expColor(input int x, input int y);
        int          tile;
        logic [15:0] w;
        logic [3:0]  fg, bg, t;
        logic [7:0]  g;
        bit          phaseOn;
        if (x >= 1280 || y >= 720) return 12'h000;
        phaseOn = ((mFrames / 30) % 2) == 0;
        tile = (y / 16) * COLS + x / 8;
        w  = mTiles[tile];
        fg = w[7:4];
        bg = w[3:0];
        if (phaseOn && tile == mRow * COLS + mCol) begin
            t = fg; fg = bg; bg = t;
        end
        g = fontRow(w[15:8], 4'(y % 16));
        return tbPalette(g[x % 8] ? fg : bg);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NT; i++) mTiles[i] = 16'h20F1;
        mCol = 0;
        mRow = 0;
        mFrames = 0;
    endtask

    task automatic modelCmd(input logic [2:0] op, input logic [7:0] data, input logic [7:0] attr);
        int p;
        case (op)
            3'd1: begin
                if (data == 8'h0A) begin
                    mCol = 0;
                    mRow = (mRow + 1) % ROWS;
                end else if (data == 8'h0D) begin
                    mCol = 0;
                end else begin
                    p = mRow * COLS + mCol;
                    mTiles[p] = {data, attr};
                    p = (p + 1) % NT;
                    mRow = p / COLS;
                    mCol = p % COLS;
                end
            end
            3'd2: begin
                case (data[1:0])
                    2'd0: if (mRow > 0) mRow--;
                    2'd1: if (mRow < ROWS - 1) mRow++;
                    2'd2: if (mCol > 0) mCol--;
                    default: if (mCol < COLS - 1) mCol++;
                endcase
            end
            3'd3: begin
                mCol = 0;
                mRow = 0;
            end
            3'd4: begin
                for (int i = 0; i < NT; i++) mTiles[i] = {8'h20, attr};
                mCol = 0;
                mRow = 0;
            end
            default: begin
            end
        endcase
    endtask

    task automatic waitClear(input string tag);
        int n = 0;
        while (cmdReady !== 1'b1 && n < 20000) begin
            n++;
            @(posedge clk); #1;
        end
        checkOutput(tag, n, 7200);
        checkOutput("cursorColAfterClear", 32'(cursorCol), 0);
        checkOutput("cursorRowAfterClear", 32'(cursorRow), 0);
    endtask

    task automatic applyReset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rstPixColor", 32'(pixColor), 0);
        checkOutput("rstCmdReady", 32'(cmdReady), 0);
        rst = 1'b0;
        modelReset();
        waitClear(tag);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data, input logic [7:0] attr);
        cmdOp = op;
        cmdData = data;
        cmdAttr = attr;
        cmdValid = 1'b1;
        checkOutput("cmdReady", 32'(cmdReady), 1);
        @(posedge clk); #1;
        cmdValid = 1'b0;
        modelCmd(op, data, attr);
        if (op != 3'd4) begin
            checkOutput("cursorCol", 32'(cursorCol), mCol);
            checkOutput("cursorRow", 32'(cursorRow), mRow);
        end
    endtask

    task automatic checkPixel(input string tag, input int x, input int y);
        pixX = 16'(x);
        pixY = 16'(y);
        repeat (3) @(posedge clk);
        #1;
        checkOutput(tag, 32'(pixColor), 32'(expColor(x, y)));
    endtask

    task automatic pulseFrame();
        frameStart = 1'b1;
        @(posedge clk); #1;
        frameStart = 1'b0;
        mFrames++;
    endtask

    initial begin
        int x, y, r;
        logic [2:0] op;
        logic [7:0] d;
        checks = 0;
        failures = 0;

        applyReset("readyLowCycles");
        for (int i = 0; i < 12; i++)
            checkPixel("resetPixel", $urandom_range(0, 1279), $urandom_range(0, 719));
        checkPixel("resetBgBlue", 100, 100);
        checkOutput("resetBgIsBlue", 32'(pixColor), 32'h00F);

        $display("[TB] putc A at home");
        applyStimulus(3'd1, 8'h41, 8'hF0);
        for (int yy = 0; yy < 16; yy++)
            checkPixel("glyphA", $urandom_range(0, 7), yy);

        $display("[TB] corner write and edge clamps");
        for (int i = 0; i < 160; i++) applyStimulus(3'd2, 8'h03, 8'h00);
        for (int i = 0; i < 46; i++) applyStimulus(3'd2, 8'h01, 8'h00);
        applyStimulus(3'd1, 8'h42, 8'h3C);
        checkOutput("wrapCol", 32'(cursorCol), 0);
        checkOutput("wrapRow", 32'(cursorRow), 0);
        for (int i = 0; i < 8; i++)
            checkPixel("tile7199", 1272 + $urandom_range(0, 7), 704 + $urandom_range(0, 15));
        applyStimulus(3'd2, 8'h02, 8'h00);
        applyStimulus(3'd2, 8'h00, 8'h00);

        $display("[TB] random commands");
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd4) op = 3'd1;
            r = $urandom_range(0, 3);
            d = (r == 0) ? 8'h0A : (r == 1) ? 8'h0D : 8'($urandom_range(33, 126));
            if (op == 3'd2) d = 8'($urandom);
            applyStimulus(op, d, 8'($urandom));
        end
        for (int i = 0; i < 20; i++)
            checkPixel("randPixelNear", $urandom_range(0, 1279), $urandom_range(0, 47));
        for (int i = 0; i < 10; i++)
            checkPixel("randPixel", $urandom_range(0, 1279), $urandom_range(0, 719));

        $display("[TB] cursor blink");
        applyStimulus(3'd3, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(3'd2, 8'h03, 8'h00);
        for (int i = 0; i < 2; i++) applyStimulus(3'd2, 8'h01, 8'h00);
        applyStimulus(3'd1, 8'h43, 8'h4E);
        applyStimulus(3'd2, 8'h02, 8'h00);
        for (int f = 0; f < 65; f++) begin
            if (f % 5 == 0) begin
                checkPixel("blinkCursor", 24 + $urandom_range(0, 7), 32 + $urandom_range(0, 15));
                checkPixel("blinkNeighbour", 32 + $urandom_range(0, 7), 32 + $urandom_range(0, 15));
            end
            pulseFrame();
        end

        $display("[TB] latency stream");
        for (int i = 0; i < 43; i++) begin
            if (i >= 3) checkOutput("stream", 32'(pixColor), 32'(streamQ.pop_front()));
            if (i < 40) begin
                case (i % 6)
                    0: begin x = 1280; y = 719; end
                    1: begin x = 1279; y = 719; end
                    2: begin x = $urandom_range(0, 1279); y = 720; end
                    default: begin x = $urandom_range(0, 1279); y = $urandom_range(0, 719); end
                endcase
                pixX = 16'(x);
                pixY = 16'(y);
                streamQ.push_back(expColor(x, y));
            end
            @(posedge clk); #1;
        end

        $display("[TB] clear interrupted by reset");
        applyStimulus(3'd4, 8'h00, 8'h20);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("clearBusy", 32'(cmdReady), 0);
        applyReset("sweepRestart");
        checkPixel("postResetTile0", 3, 5);
        checkPixel("postResetTile7199", 1275, 710);
        checkPixel("postResetCursor", 2, 2);
        for (int i = 0; i < 6; i++)
            checkPixel("postResetPixel", $urandom_range(0, 1279), $urandom_range(0, 719));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
